// File: rtl/memory_controller_pkg.sv
// Shared definitions for the byte-wide RAM port controller: state encodings,
// access codes and byte-lane helpers.
package memory_controller_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_IF_READ  = 3'd1,
      ST_LS_READ  = 3'd2,
      ST_LS_WRITE = 3'd3,
      ST_DONE     = 3'd4
   } mc_state_e;

   localparam logic       OP_READ        = 1'b0;
   localparam logic       OP_WRITE       = 1'b1;
   localparam logic [2:0] WIDTH_BYTE     = 3'd1;
   localparam logic [2:0] WIDTH_HALF     = 3'd2;
   localparam logic [2:0] WIDTH_WORD     = 3'd4;
   localparam logic [1:0] IO_ADDR_HI_DEF = 2'b11;

   // Unsupported width codes fall back to a full word.
   function automatic logic [2:0] width_bytes(input logic [2:0] code);
      case (code)
         WIDTH_BYTE: return WIDTH_BYTE;
         WIDTH_HALF: return WIDTH_HALF;
         WIDTH_WORD: return WIDTH_WORD;
         default:    return WIDTH_WORD;
      endcase
   endfunction

   function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] idx);
      return word[{idx, 3'b000} +: 8];
   endfunction

   function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] idx,
                                            input logic [7:0] b);
      logic [31:0] r;
      r = word;
      r[{idx, 3'b000} +: 8] = b;
      return r;
   endfunction

endpackage

// File: rtl/memory_controller.sv
// Sole owner of the byte-wide RAM port: arbitrates fetch and load/store requests
// and serialises 1/2/4-byte accesses into byte cycles with one-cycle done pulses.
module memory_controller
   import memory_controller_pkg::*;
#(
   parameter int         ADDR_WIDTH = 32,
   parameter logic [1:0] IO_ADDR_HI = IO_ADDR_HI_DEF
) (
   input  logic                  Sys_clk,
   input  logic                  Sys_rst,
   input  logic                  Sys_rdy,
   input  logic                  RoBMC_pre_judge,
   input  logic                  ICMC_en,
   input  logic [ADDR_WIDTH-1:0] ICMC_addr,
   output logic                  MCIC_en,
   output logic [31:0]           MCIC_data,
   input  logic                  LSBMC_en,
   input  logic                  LSBMC_wr,
   input  logic [2:0]            LSBMC_data_width,
   input  logic [31:0]           LSBMC_data,
   input  logic [ADDR_WIDTH-1:0] LSBMC_addr,
   output logic                  MCLSB_r_en,
   output logic                  MCLSB_w_en,
   output logic [31:0]           MCLSB_data,
   input  logic [7:0]            mem_din,
   output logic [7:0]            mem_dout,
   output logic [ADDR_WIDTH-1:0] mem_a,
   output logic                  mem_wr,
   input  logic                  io_buffer_full
);

   mc_state_e             state_r;
   logic [ADDR_WIDTH-1:0] base_r;
   logic [2:0]            nbytes_r;
   logic [31:0]           wdata_r;
   logic [2:0]            cyc_r;
   logic [31:0]           acc_r;
   logic                  rdy_q_r;
   logic [7:0]            din_hold_r;
   logic [ADDR_WIDTH-1:0] mem_a_r;
   logic [7:0]            mem_dout_r;
   logic                  mem_wr_r;

   logic                  io_stall_s;
   logic [1:0]            cap_idx_s;
   logic [7:0]            cap_byte_s;
   logic [31:0]           merged_s;
   logic [ADDR_WIDTH-1:0] next_a_s;

   // Writes into the IO window stall while the IO output buffer is full.
   always_comb begin
      io_stall_s = 1'b0;
      if (state_r == ST_LS_WRITE && base_r[17:16] == IO_ADDR_HI && io_buffer_full) begin
         io_stall_s = 1'b1;
      end else begin
         io_stall_s = 1'b0;
      end
   end

   // RAM returns the byte one cycle late; after a freeze the byte seen on the
   // first frozen cycle is the one still owed, so it is replayed from din_hold_r.
   always_comb begin
      cap_idx_s  = 2'(cyc_r - 3'd2);
      cap_byte_s = rdy_q_r ? mem_din : din_hold_r;
      merged_s   = put_byte(acc_r, cap_idx_s, cap_byte_s);
      next_a_s   = base_r + ADDR_WIDTH'(cyc_r);
   end

   assign mem_wr   = mem_wr_r & Sys_rdy & ~io_stall_s;
   assign mem_a    = io_stall_s ? '0 : mem_a_r;
   assign mem_dout = io_stall_s ? 8'h00 : mem_dout_r;

   // Request arbitration, byte sequencing and done-pulse generation.
   always_ff @(posedge Sys_clk or posedge Sys_rst) begin
      if (Sys_rst) begin
         state_r    <= ST_IDLE;
         base_r     <= '0;
         nbytes_r   <= 3'd0;
         wdata_r    <= 32'd0;
         cyc_r      <= 3'd0;
         acc_r      <= 32'd0;
         rdy_q_r    <= 1'b0;
         din_hold_r <= 8'h00;
         mem_a_r    <= '0;
         mem_dout_r <= 8'h00;
         mem_wr_r   <= 1'b0;
         MCIC_en    <= 1'b0;
         MCIC_data  <= 32'd0;
         MCLSB_r_en <= 1'b0;
         MCLSB_w_en <= 1'b0;
         MCLSB_data <= 32'd0;
      end else begin
         rdy_q_r <= Sys_rdy;
         if (!Sys_rdy) begin
            if (rdy_q_r) begin
               din_hold_r <= mem_din;
            end
         end else begin
            case (state_r)
               ST_IDLE: begin
                  if (RoBMC_pre_judge && LSBMC_en) begin
                     base_r   <= LSBMC_addr;
                     nbytes_r <= width_bytes(LSBMC_data_width);
                     wdata_r  <= LSBMC_data;
                     acc_r    <= 32'd0;
                     cyc_r    <= 3'd1;
                     mem_a_r  <= LSBMC_addr;
                     mem_wr_r <= (LSBMC_wr == OP_WRITE);
                     if (LSBMC_wr == OP_READ) begin
                        state_r <= ST_LS_READ;
                     end else begin
                        state_r    <= ST_LS_WRITE;
                        mem_dout_r <= LSBMC_data[7:0];
                     end
                  end else if (RoBMC_pre_judge && ICMC_en) begin
                     state_r  <= ST_IF_READ;
                     base_r   <= ICMC_addr;
                     nbytes_r <= WIDTH_WORD;
                     acc_r    <= 32'd0;
                     cyc_r    <= 3'd1;
                     mem_a_r  <= ICMC_addr;
                  end
               end
               ST_IF_READ, ST_LS_READ: begin
                  if (state_r == ST_IF_READ && !RoBMC_pre_judge) begin
                     state_r <= ST_IDLE;
                     mem_a_r <= '0;
                  end else begin
                     if (cyc_r >= 3'd2) begin
                        acc_r <= merged_s;
                     end
                     mem_a_r <= (cyc_r < nbytes_r) ? next_a_s : '0;
                     if (cyc_r == nbytes_r + 3'd1) begin
                        state_r <= ST_DONE;
                        if (state_r == ST_IF_READ) begin
                           MCIC_en   <= 1'b1;
                           MCIC_data <= merged_s;
                        end else begin
                           MCLSB_r_en <= 1'b1;
                           MCLSB_data <= merged_s;
                        end
                     end
                     cyc_r <= cyc_r + 3'd1;
                  end
               end
               ST_LS_WRITE: begin
                  if (!io_stall_s) begin
                     if (cyc_r < nbytes_r) begin
                        mem_a_r    <= next_a_s;
                        mem_dout_r <= get_byte(wdata_r, 2'(cyc_r));
                        cyc_r      <= cyc_r + 3'd1;
                     end else begin
                        state_r    <= ST_DONE;
                        MCLSB_w_en <= 1'b1;
                        mem_wr_r   <= 1'b0;
                        mem_a_r    <= '0;
                        mem_dout_r <= 8'h00;
                     end
                  end
               end
               ST_DONE: begin
                  MCIC_en    <= 1'b0;
                  MCLSB_r_en <= 1'b0;
                  MCLSB_w_en <= 1'b0;
                  state_r    <= ST_IDLE;
               end
               default: begin
                  state_r  <= ST_IDLE;
                  mem_wr_r <= 1'b0;
                  mem_a_r  <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_memory_controller.sv
// Randomised and directed bench for memory_controller against a byte-array
// reference model of the RAM and transaction-level latency rules.
module tb_memory_controller;

   logic        Sys_clk = 1'b0;
   logic        Sys_rst, Sys_rdy, RoBMC_pre_judge;
   logic        ICMC_en, LSBMC_en, LSBMC_wr, io_buffer_full;
   logic [31:0] ICMC_addr, LSBMC_data, LSBMC_addr;
   logic [2:0]  LSBMC_data_width;
   logic        MCIC_en, MCLSB_r_en, MCLSB_w_en, mem_wr;
   logic [31:0] MCIC_data, MCLSB_data, mem_a;
   logic [7:0]  mem_din, mem_dout;

   memory_controller dut (
      .Sys_clk(Sys_clk), .Sys_rst(Sys_rst), .Sys_rdy(Sys_rdy), .RoBMC_pre_judge(RoBMC_pre_judge),
      .ICMC_en(ICMC_en), .ICMC_addr(ICMC_addr), .MCIC_en(MCIC_en), .MCIC_data(MCIC_data),
      .LSBMC_en(LSBMC_en), .LSBMC_wr(LSBMC_wr), .LSBMC_data_width(LSBMC_data_width),
      .LSBMC_data(LSBMC_data), .LSBMC_addr(LSBMC_addr), .MCLSB_r_en(MCLSB_r_en),
      .MCLSB_w_en(MCLSB_w_en), .MCLSB_data(MCLSB_data), .mem_din(mem_din), .mem_dout(mem_dout),
      .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
   );

   always #5 Sys_clk = ~Sys_clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0]  dev_ram   [logic [31:0]];
   logic [7:0]  model_mem [logic [31:0]];
   logic [31:0] tr_a  [0:63];
   logic        tr_wr [0:63];
   logic [7:0]  tr_do [0:63];

   // Background RAM contents; 0x100..0x103 hold 11 22 33 44.
   function automatic logic [7:0] init_byte(input logic [31:0] a);
      if (a >= 32'h100 && a < 32'h104) return 8'(8'h11 * (a - 32'hFF));
      return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
   endfunction

   function automatic logic [7:0] model_rd(input logic [31:0] a);
      return model_mem.exists(a) ? model_mem[a] : init_byte(a);
   endfunction

   function automatic logic [7:0] dev_rd(input logic [31:0] a);
      return dev_ram.exists(a) ? dev_ram[a] : init_byte(a);
   endfunction

   function automatic logic [31:0] exp_read(input logic [31:0] a, input int n);
      logic [31:0] r;
      r = 32'd0;
      for (int k = 0; k < n; k++) r[8*k +: 8] = model_rd(a + 32'(k));
      return r;
   endfunction

   // Byte-wide synchronous RAM: data for the address of one cycle appears the next.
   always @(posedge Sys_clk) begin
      logic [7:0] rv;
      rv = dev_rd(mem_a);
      if (mem_wr) dev_ram[mem_a] = mem_dout;
      mem_din <= rv;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Sys_clk);
      #1;
   endtask

   task automatic launch_lsb(input bit wr, input int n, input logic [31:0] a, input logic [31:0] d);
      LSBMC_en = 1'b1; LSBMC_wr = wr; LSBMC_data_width = 3'(n); LSBMC_addr = a; LSBMC_data = d;
      if (wr) for (int k = 0; k < n; k++) model_mem[a + 32'(k)] = d[8*k +: 8];
      tick();
      LSBMC_en = 1'b0; LSBMC_addr = $urandom; LSBMC_data = $urandom; LSBMC_wr = ~wr;
   endtask

   task automatic launch_if(input logic [31:0] a);
      ICMC_en = 1'b1; ICMC_addr = a;
      tick();
      ICMC_en = 1'b0; ICMC_addr = $urandom;
   endtask

   // Steps cycles 1..budget after an accept edge, tracing the RAM port until a done pulse.
   task automatic watch(input int budget, input int flush_at, input int io_from, input int io_to,
                        input bit rnd, output int pcyc, output int pkind,
                        output logic [31:0] pdata, output int nwr);
      pcyc = -1; pkind = 0; pdata = 32'd0; nwr = 0;
      for (int k = 1; k <= budget; k++) begin
         RoBMC_pre_judge = (k != flush_at);
         if (rnd) begin
            Sys_rdy = ($urandom_range(0, 3) != 0);
            io_buffer_full = 1'($urandom_range(0, 1));
         end else begin
            Sys_rdy = 1'b1;
            io_buffer_full = (k >= io_from && k <= io_to);
         end
         #1;
         if (k < 64) begin tr_a[k] = mem_a; tr_wr[k] = mem_wr; tr_do[k] = mem_dout; end
         nwr += int'(mem_wr);
         if (MCIC_en || MCLSB_r_en || MCLSB_w_en) begin
            pcyc = k;
            pkind = MCIC_en ? 1 : (MCLSB_r_en ? 2 : 3);
            pdata = MCIC_en ? MCIC_data : MCLSB_data;
            break;
         end
         tick();
      end
      RoBMC_pre_judge = 1'b1; io_buffer_full = 1'b0; Sys_rdy = 1'b1;
   endtask

   int          pc, pk, nw, n, op;
   logic [31:0] pd, a, d, e;

   initial begin
      Sys_rst = 1'b1; Sys_rdy = 1'b1; RoBMC_pre_judge = 1'b1; ICMC_en = 1'b0; ICMC_addr = 32'd0;
      LSBMC_en = 1'b0; LSBMC_wr = 1'b0; LSBMC_data_width = 3'd0; LSBMC_data = 32'd0;
      LSBMC_addr = 32'd0; io_buffer_full = 1'b0;
      tick(); tick();
      check_eq("rst_pulses", {MCIC_en, MCLSB_r_en, MCLSB_w_en, mem_wr}, 4'b0000);
      check_eq("rst_mem_a", mem_a, 32'd0);
      check_eq("rst_data", MCIC_data | MCLSB_data | {24'd0, mem_dout}, 32'd0);
      Sys_rst = 1'b0;
      tick();

      // lw 0x100
      launch_lsb(1'b0, 4, 32'h100, 32'd0);
      watch(20, 0, 0, 0, 1'b0, pc, pk, pd, nw);
      check_eq("lw_cycle", pc, 6);
      check_eq("lw_kind", pk, 2);
      check_eq("lw_data", pd, 32'h44332211);
      check_eq("lw_addrs", {tr_a[1], tr_a[2], tr_a[3], tr_a[4]}, {32'h100, 32'h101, 32'h102, 32'h103});
      check_eq("lw_no_wr", nw, 0);
      tick();
      check_eq("lw_one_pulse", MCLSB_r_en, 1'b0);

      // sh 0x0002
      launch_lsb(1'b1, 2, 32'h2, 32'h1234BEEF);
      watch(20, 0, 0, 0, 1'b0, pc, pk, pd, nw);
      check_eq("sh_cycle", pc, 3);
      check_eq("sh_kind", pk, 3);
      check_eq("sh_bytes", {tr_wr[1], tr_a[1], tr_do[1], tr_wr[2], tr_a[2], tr_do[2]},
               {1'b1, 32'h2, 8'hEF, 1'b1, 32'h3, 8'hBE});
      check_eq("sh_nwr", nw, 2);
      check_eq("sh_hold_rdata", MCLSB_data, 32'h44332211);
      tick();

      // simultaneous fetch and data request
      ICMC_en = 1'b1; ICMC_addr = 32'h104;
      launch_lsb(1'b0, 4, 32'h100, 32'd0);
      watch(20, 0, 0, 0, 1'b0, pc, pk, pd, nw);
      check_eq("arb_lsb_first", {pk[7:0], pc[7:0]}, {8'd2, 8'd6});
      tick();
      watch(20, 0, 0, 0, 1'b0, pc, pk, pd, nw);
      ICMC_en = 1'b0;
      check_eq("arb_if_cycle", {pk[7:0], pc[7:0]}, {8'd1, 8'd7});
      check_eq("arb_if_data", pd, exp_read(32'h104, 4));
      tick();

      // flush during fetch aborts it; flush during lw does not
      launch_if(32'h300);
      watch(12, 2, 0, 0, 1'b0, pc, pk, pd, nw);
      check_eq("if_flush_no_pulse", pc, -1);
      check_eq("if_flush_idle_a", tr_a[3], 32'd0);
      launch_lsb(1'b0, 4, 32'h100, 32'd0);
      watch(20, 3, 0, 0, 1'b0, pc, pk, pd, nw);
      check_eq("lw_flush", {pk[7:0], pc[7:0], pd}, {8'd2, 8'd6, 32'h44332211});
      tick();

      // IO write stall
      launch_lsb(1'b1, 1, 32'h30000, 32'h0000005A);
      watch(20, 0, 1, 3, 1'b0, pc, pk, pd, nw);
      check_eq("io_stall_wr", {tr_wr[1], tr_wr[2], tr_wr[3], tr_wr[4]}, 4'b0001);
      check_eq("io_stall_a", tr_a[2], 32'd0);
      check_eq("io_write", {tr_a[4], tr_do[4]}, {32'h30000, 8'h5A});
      check_eq("io_wen", {pk[7:0], pc[7:0], nw[7:0]}, {8'd3, 8'd5, 8'd1});
      tick();
      launch_lsb(1'b1, 1, 32'h20000, 32'h000000C3);
      watch(20, 0, 1, 3, 1'b0, pc, pk, pd, nw);
      check_eq("non_io_no_stall", {pk[7:0], pc[7:0], nw[7:0]}, {8'd3, 8'd2, 8'd1});
      tick();

      // lb latency and lh wrapping past the top of the address space
      launch_lsb(1'b0, 1, 32'h101, 32'd0);
      watch(20, 0, 0, 0, 1'b0, pc, pk, pd, nw);
      check_eq("lb", {pc[7:0], pd}, {8'd3, 32'h00000022});
      tick();
      launch_lsb(1'b0, 2, 32'hFFFFFFFF, 32'd0);
      watch(20, 0, 0, 0, 1'b0, pc, pk, pd, nw);
      check_eq("lh_wrap", {pc[7:0], pd, tr_a[2]}, {8'd4, exp_read(32'hFFFFFFFF, 2), 32'd0});
      tick();

      // reset in the middle of a lw
      launch_lsb(1'b0, 4, 32'h100, 32'd0);
      watch(2, 0, 0, 0, 1'b0, pc, pk, pd, nw);
      Sys_rst = 1'b1;
      #1;
      check_eq("midrst_outs", {mem_a, mem_wr, MCLSB_r_en, MCLSB_data}, 66'd0);
      tick();
      Sys_rst = 1'b0;
      watch(10, 0, 0, 0, 1'b0, pc, pk, pd, nw);
      check_eq("midrst_no_pulse", pc, -1);
      launch_lsb(1'b0, 4, 32'h100, 32'd0);
      watch(20, 0, 0, 0, 1'b0, pc, pk, pd, nw);
      check_eq("post_rst_lw", {pc[7:0], pd}, {8'd6, 32'h44332211});
      tick();

      // randomised traffic with freezes and IO back-pressure
      for (int i = 0; i < 80; i++) begin
         op = $urandom_range(0, 6);
         a  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7))
                                          : 32'h1000 + 32'($urandom_range(0, 63));
         d  = $urandom;
         n  = (op % 3 == 0) ? 1 : ((op % 3 == 1) ? 2 : 4);
         if (op == 6) begin
            n = 4;
            e = exp_read(a, 4);
            launch_if(a);
         end else begin
            e = exp_read(a, n);
            launch_lsb(op >= 3, n, a, d);
         end
         watch(80, 0, 0, 0, (i % 2) == 1, pc, pk, pd, nw);
         if (op == 6) begin
            check_eq("rnd_fetch", {pk[7:0], pd}, {8'd1, e});
         end else if (op < 3) begin
            check_eq("rnd_read", {pk[7:0], pd}, {8'd2, e});
         end else begin
            check_eq("rnd_write", {pk[7:0], nw[7:0]}, {8'd3, 8'(n)});
         end
         if (i % 2 == 0) check_eq("rnd_latency", pc, (op >= 3 && op < 6) ? n + 1 : n + 2);
         tick();
      end

      for (int k = 0; k < 64; k++) check_eq("sweep_lo", dev_rd(32'h1000 + 32'(k)), model_rd(32'h1000 + 32'(k)));
      for (int k = 0; k < 16; k++) check_eq("sweep_hi", dev_rd(32'hFFFFFFF8 + 32'(k)), model_rd(32'hFFFFFFF8 + 32'(k)));
      check_eq("sweep_io", dev_rd(32'h30000), 8'h5A);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
